// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, the NOP
// encoding, and the default boot PC.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory,
// buffers one instruction for IF/ID, and handles stalls and EX redirects.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned     N        = 32,
    parameter logic [N-1:0]    RESET_PC = N'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [N-1:0] redirect_pc_i,
    output logic         imem_req_o,
    output logic [N-1:0] imem_addr_o,
    input  logic         imem_ack_i,
    input  logic [N-1:0] imem_rdata_i,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] pc4_o,
    output logic [N-1:0] inst_o,
    output logic         inst_valid_o,
    output logic         if_id_enable_o,
    output logic         flush_o
);

    fetch_state_e state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] inst_q, inst_d;
    logic [N-1:0] ipc_q, ipc_d;
    logic [N-1:0] ipc4_q, ipc4_d;
    logic         valid_q, valid_d;
    logic         pend_q, pend_d;
    logic         take;
    logic [N-1:0] redirect_tgt;
    logic         unused_rpc_lsb;

    assign take           = ~valid_q | ~stall_i;
    assign redirect_tgt   = {redirect_pc_i[N-1:2], 2'b00};
    assign unused_rpc_lsb = ^redirect_pc_i[1:0];

    assign imem_addr_o    = {pc_q[N-1:2], 2'b00};
    assign imem_req_o     = (state_q == FETCH) & take & ~redirect_i;
    assign flush_o        = redirect_i;
    assign if_id_enable_o = ~stall_i | redirect_i;
    assign pc_o           = ipc_q;
    assign pc4_o          = ipc4_q;
    assign inst_o         = inst_q;
    assign inst_valid_o   = valid_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        valid_d = valid_q;
        pend_d  = pend_q;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                pend_d  = 1'b0;
            end
            FETCH: begin
                if (redirect_i) begin
                    // A request held without ack is still owed by memory; drain it.
                    if (pend_q & ~imem_ack_i) state_d = DRAIN;
                    pend_d = 1'b0;
                end else if (take) begin
                    if (imem_ack_i) begin
                        inst_d  = imem_rdata_i;
                        ipc_d   = pc_q;
                        ipc4_d  = pc_q + N'(4);
                        valid_d = 1'b1;
                        pc_d    = pc_q + N'(4);
                        pend_d  = 1'b0;
                    end else begin
                        valid_d = 1'b0;
                        inst_d  = N'(NOP_INST);
                        pend_d  = 1'b1;
                    end
                end else begin
                    pend_d = pend_q & ~imem_ack_i;
                end
            end
            DRAIN: begin
                pend_d = 1'b0;
                if (imem_ack_i) state_d = FETCH;
            end
            default: begin
                state_d = BOOT;
                pend_d  = 1'b0;
            end
        endcase

        if (redirect_i) begin
            pc_d    = redirect_tgt;
            valid_d = 1'b0;
            inst_d  = N'(NOP_INST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= N'(NOP_INST);
            ipc_q   <= RESET_PC;
            ipc4_q  <= RESET_PC + N'(4);
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-built latency/reset
// sequences, and randomized traffic checked against a transaction-level model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        if_id_enable_o;
    logic        flush_o;

    if_fetch_unit #(.N(32), .RESET_PC(32'h0040_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .pc_o           (pc_o),
        .pc4_o          (pc4_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o),
        .if_id_enable_o (if_id_enable_o),
        .flush_o        (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: latency 0 acks combinationally; latency L acks L cycles after accepting.
    int          lat = 0;
    logic        force_ack = 1'b0;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        mem_ack;

    assign mem_ack      = (lat == 0) ? imem_req_o : (mem_busy && mem_cnt == 0);
    assign imem_ack_i   = mem_ack | force_ack;
    assign imem_rdata_i = force_ack ? 32'hBAD0_BAD0 :
                          (mem_ack ? data_of((lat == 0) ? imem_addr_o : mem_addr) : 32'hDEAD_BEEF);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_busy <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= '0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end else if (lat != 0 && imem_req_o) begin
            mem_busy <= 1'b1;
            mem_cnt  <= lat - 1;
            mem_addr <= imem_addr_o;
        end
    end

    // Reference model: next fetch PC, a one-entry buffer, and a count of acks
    // still owed for abandoned requests.
    bit          m_boot;
    int          m_owed;
    bit          m_fly;
    bit          m_full;
    logic [31:0] m_inst, m_pc, m_npc;

    task automatic model_reset();
        m_boot = 1; m_owed = 0; m_fly = 0; m_full = 0;
        m_inst = NOP; m_pc = RST_PC; m_npc = RST_PC;
    endtask

    function automatic bit exp_req(input bit st, input bit rd);
        return !m_boot && m_owed == 0 && (!m_full || !st) && !rd;
    endfunction

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                              input bit ack, input logic [31:0] rdata);
        logic [31:0] tgt;
        bit          tk;
        tgt = rpc & 32'hFFFF_FFFC;
        tk  = !m_full || !st;
        if (m_boot) begin
            m_boot = 0;
            if (rd) m_npc = tgt;
        end else if (rd) begin
            if (m_owed > 0) begin
                if (ack) m_owed = m_owed - 1;
            end else if (m_fly && !ack) begin
                m_owed = 1;
            end
            m_fly = 0; m_full = 0; m_inst = NOP; m_npc = tgt;
        end else if (m_owed > 0) begin
            if (ack) m_owed = m_owed - 1;
        end else if (tk) begin
            if (ack) begin
                m_full = 1; m_inst = rdata; m_pc = m_npc; m_npc = m_npc + 32'd4; m_fly = 0;
            end else begin
                m_full = 0; m_inst = NOP; m_fly = 1;
            end
        end else if (ack) begin
            m_fly = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input bit st, input bit rd);
        logic [31:0] pc4_exp;
        pc4_exp = m_pc + 32'd4;
        chk("req",      {31'd0, imem_req_o},     {31'd0, exp_req(st, rd)});
        chk("addr",     imem_addr_o,             m_npc);
        chk("flush",    {31'd0, flush_o},        {31'd0, rd});
        chk("if_id_en", {31'd0, if_id_enable_o}, {31'd0, (!st || rd)});
        chk("valid",    {31'd0, inst_valid_o},   {31'd0, m_full});
        chk("inst",     inst_o,                  m_inst);
        chk("pc",       pc_o,                    m_pc);
        chk("pc4",      pc4_o,                   pc4_exp);
    endtask

    bit          cur_st, cur_rd;
    logic [31:0] cur_rpc;

    // drive/advance start and end on a falling clock edge.
    task automatic drive(input bit st, input bit rd, input logic [31:0] rpc);
        cur_st = st; cur_rd = rd; cur_rpc = rpc;
        stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
        #1;
        check_cycle(st, rd);
    endtask

    task automatic advance();
        model_step(cur_st, cur_rd, cur_rpc, imem_ack_i, imem_rdata_i);
        @(negedge clk);
        force_ack = 1'b0;
    endtask

    task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
        drive(st, rd, rpc);
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b0; force_ack = 1'b0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        #1;
        model_reset();
        check_cycle(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        bit          fa;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [31:0] e_inst, e_pc4;
        reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

        tbl[0]  = '{0, 0, 32'h0,         0, 0, 32'h0040_0000, 0, 32'h0040_0000};
        tbl[1]  = '{0, 0, 32'h0,         0, 1, 32'h0040_0000, 0, 32'h0040_0000};
        tbl[2]  = '{0, 0, 32'h0,         0, 1, 32'h0040_0004, 1, 32'h0040_0000};
        tbl[3]  = '{0, 0, 32'h0,         0, 1, 32'h0040_0008, 1, 32'h0040_0004};
        for (int i = 4; i <= 8; i++)
            tbl[i] = '{1, 0, 32'h0,      0, 0, 32'h0040_000C, 1, 32'h0040_0008};
        tbl[9]  = '{0, 0, 32'h0,         0, 1, 32'h0040_000C, 1, 32'h0040_0008};
        tbl[10] = '{0, 1, 32'h0040_0102, 0, 0, 32'h0040_0010, 1, 32'h0040_000C};
        tbl[11] = '{0, 0, 32'h0,         0, 1, 32'h0040_0100, 0, 32'h0040_000C};
        tbl[12] = '{0, 0, 32'h0,         0, 1, 32'h0040_0104, 1, 32'h0040_0100};
        tbl[13] = '{1, 1, 32'h0040_0203, 1, 0, 32'h0040_0108, 1, 32'h0040_0104};
        tbl[14] = '{0, 0, 32'h0,         0, 1, 32'h0040_0200, 0, 32'h0040_0104};
        tbl[15] = '{0, 0, 32'h0,         0, 1, 32'h0040_0204, 1, 32'h0040_0200};
        tbl[16] = '{0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0040_0208, 1, 32'h0040_0204};
        tbl[17] = '{0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0040_0204};
        tbl[18] = '{0, 0, 32'h0,         0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC};
        tbl[19] = '{0, 0, 32'h0,         0, 1, 32'h0000_0004, 1, 32'h0000_0000};

        @(negedge clk);

        // Directed table, zero-wait memory
        lat = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            force_ack = tbl[i].fa;
            drive(tbl[i].st, tbl[i].rd, tbl[i].rpc);
            e_inst = tbl[i].e_valid ? data_of(tbl[i].e_pc) : NOP;
            e_pc4  = tbl[i].e_pc + 32'd4;
            chk($sformatf("tbl%0d_req", i),   {31'd0, imem_req_o},     {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_addr", i),  imem_addr_o,             tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, inst_valid_o},   {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_pc", i),    pc_o,                    tbl[i].e_pc);
            chk($sformatf("tbl%0d_pc4", i),   pc4_o,                   e_pc4);
            chk($sformatf("tbl%0d_inst", i),  inst_o,                  e_inst);
            chk($sformatf("tbl%0d_flush", i), {31'd0, flush_o},        {31'd0, tbl[i].rd});
            chk($sformatf("tbl%0d_en", i),    {31'd0, if_id_enable_o}, {31'd0, (!tbl[i].st || tbl[i].rd)});
            advance();
        end

        // Redirect while a request is in flight (memory latency 2)
        lat = 2;
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        drive(0, 1, 32'h0040_0102);
        chk("drain_flush", {31'd0, flush_o}, 32'd1);
        advance();
        drive(0, 0, 0);
        chk("drain_req_low", {31'd0, imem_req_o}, 32'd0);
        advance();
        drive(0, 0, 0);
        chk("drain_new_req",  {31'd0, imem_req_o},   32'd1);
        chk("drain_new_addr", imem_addr_o,           32'h0040_0100);
        chk("drain_invalid",  {31'd0, inst_valid_o}, 32'd0);
        advance();
        step(0, 0, 0);
        step(0, 0, 0);
        drive(0, 0, 0);
        chk("drain_first_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("drain_first_pc",    pc_o,                  32'h0040_0100);
        chk("drain_first_inst",  inst_o,                data_of(32'h0040_0100));
        advance();

        // Reset asserted while draining; a late ack during boot is ignored
        lat = 3;
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 32'h0040_0300);
        step(0, 0, 0);
        do_reset();
        chk("rst_drain_req",   {31'd0, imem_req_o},   32'd0);
        chk("rst_drain_valid", {31'd0, inst_valid_o}, 32'd0);
        force_ack = 1'b1;
        step(0, 0, 0);
        drive(0, 0, 0);
        chk("rst_boot_req",  {31'd0, imem_req_o}, 32'd1);
        chk("rst_boot_addr", imem_addr_o,         RST_PC);
        advance();
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        drive(0, 0, 0);
        chk("rst_first_pc",   pc_o,   RST_PC);
        chk("rst_first_inst", inst_o, data_of(RST_PC));
        advance();

        // Randomized traffic across memory latencies
        for (int ph = 0; ph < 4; ph++) begin
            lat = ph;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                bit          st, rd;
                logic [31:0] rpc;
                st  = ($urandom_range(0, 99) < 30);
                rd  = ($urandom_range(0, 99) < 7);
                rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : (RST_PC + ($urandom & 32'h0000_0FFF));
                step(st, rd, rpc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC, issues requests to instruction memory over a req/ack handshake, and buffers one fetched instruction with its PC and PC+4.
- Presents the buffered instruction to IF/ID; applies hazard-unit stalls and EX-stage branch/jump redirects, discarding stale in-flight fetches.

Parameters:
- N, 32, datapath/address width.
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  reset, asynchronous, active-low.
- stall_i  input  1  hazard stall; hold buffered instruction and PC.
- redirect_i  input  1  taken branch/jump from EX.
- redirect_pc_i  input  N  redirect target.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  N  fetch address; word aligned.
- imem_ack_i  input  1  memory returns data this cycle.
- imem_rdata_i  input  N  fetched instruction word.
- pc_o  output  N  PC of buffered instruction.
- pc4_o  output  N  pc_o + 4.
- inst_o  output  N  buffered instruction; NOP when invalid.
- inst_valid_o  output  1  buffer holds a valid instruction.
- if_id_enable_o  output  1  enable to IF/ID register.
- flush_o  output  1  clear IF/ID this cycle.

Behaviour:
- Reset (async, reset==0):
  - state=BOOT, pc_q=RESET_PC.
  - inst_valid_o=0, inst_o=32'h0000_0013 (NOP).
  - pc_o=RESET_PC, pc4_o=RESET_PC+4.
  - imem_req_o=0.
- Reset mid-operation: any outstanding request is abandoned; memory must tolerate req dropping.
- All state updates occur on the rising clk edge.
- imem_addr_o = {pc_q[N-1:2],2'b00} at all times.
- take = ~inst_valid_o | ~stall_i. The buffer may accept new data only when take==1.
- BOOT: imem_req_o=0 for exactly one cycle after reset release, then go to FETCH.
- FETCH:
  - imem_req_o = take & ~redirect_i.
  - While req is high and ack is low, address is held stable.
  - On imem_ack_i & take & ~redirect_i:
    - inst_o<=imem_rdata_i, pc_o<=pc_q, pc4_o<=pc_q+4, inst_valid_o<=1, pc_q<=pc_q+4.
    - Zero-wait memory sustains one instruction per cycle.
  - No ack and take==1 with inst_valid_o==1 (IF/ID consuming): inst_valid_o<=0 and inst_o<=NOP (bubble).
  - take==0: buffer and pc_q are frozen; req is low.
- Redirect (priority over stall and ack):
  - flush_o=redirect_i (combinational).
  - Next edge: pc_q<={redirect_pc_i[N-1:2],2'b00}, inst_valid_o<=0, inst_o<=NOP.
  - If in FETCH with req high and no ack this cycle (request in flight), go to DRAIN. Otherwise stay in FETCH.
  - Any ack in the redirect cycle is discarded.
- DRAIN:
  - imem_req_o=0. Wait for the ack of the abandoned request and discard its data.
  - On ack, go to FETCH; the first new request is issued next cycle.
  - A redirect while in DRAIN overwrites pc_q with the newest target and stays in DRAIN.
- Memory protocol: the memory must return exactly one ack per request edge it accepted.
- if_id_enable_o = ~stall_i | redirect_i.
- Stall plus redirect in the same cycle: redirect wins; flush is applied.
- PC arithmetic is modulo 2^N; 32'hFFFF_FFFC+4 wraps to 0.
- Redirect low bits [1:0] are ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding {BOOT, FETCH, DRAIN}.
  - NOP_INST = 32'h0000_0013.
  - DEFAULT_RESET_PC.
- No sub-module; the PC adder and next-PC mux stay inline.

Test Plan:
- Reset/boot: assert then release reset -> pc_o=0x00400000, inst_o=0x00000013, valid=0; req low for 1 cycle, then high with addr 0x00400000.
- Zero-wait stream: ack every cycle with words A,B,C -> pc_o sequence 0x00400000/04/08; pc4_o = pc_o+4; valid stays 1.
- Stall: stall_i=1 with buffer valid -> req=0, if_id_enable_o=0, all outputs frozen 5 cycles; on release, fetch resumes at the next PC.
- Redirect mid-fetch (2-cycle ack latency): redirect_pc_i=0x00400102 while a request is pending -> flush_o=1 and the stale word is dropped; next request addr is 0x00400100 and valid stays 0 until its ack.
- Redirect + stall + ack in the same cycle -> ack data discarded, flush_o=1, if_id_enable_o=1, pc_q=target.
- Reset asserted in DRAIN -> req=0 immediately; after release, BOOT then fetch at RESET_PC; a late ack is ignored.
